// File: rtl/nios_dbg_vjtag_pkg.sv
// Shared types and constants for the Nios II debug virtual-JTAG initiator.
// Latency: none (declarations only).
// Backpressure: not applicable.
package nios_dbg_vjtag_pkg;

    localparam int DEF_DR_WIDTH = 38;
    localparam int DEF_IR_WIDTH = 2;
    localparam int DEF_TCK_DIV  = 4;

    // Virtual IR codes understood by the debug slave
    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACEMEM  = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RTI,
        ST_DONE
    } state_e;

endpackage

// File: rtl/nios_dbg_vjtag_if.sv
// Command/response handshake bundle between a bring-up controller and the vJTAG initiator.
// Latency: none (wires only).
// Backpressure: cmd_ready gates commands; rsp_valid is held until rsp_ready.
interface nios_dbg_vjtag_if #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_dr;

    // Controller side: issues commands, consumes responses
    modport master (
        output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_dr
    );

    // Initiator side: accepts commands, produces responses
    modport slave (
        input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        output cmd_ready, rsp_valid, rsp_dr
    );
endinterface

// File: rtl/nios_dbg_vjtag_tck_gen.sv
// Test-clock divider: tck plus tdo-sample and state-advance strobes, running only while enabled.
// Latency: tck rises TCK_DIV/2 clk after enable; tick every TCK_DIV clk.
// Backpressure: none; en low parks the counter at 0 with tck low.
module nios_dbg_vjtag_tck_gen #(
    parameter int TCK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tck,
    output logic tick,
    output logic sample
);
    localparam int CW = (TCK_DIV > 2) ? $clog2(TCK_DIV) : 1;

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;

    // Divider next value: wraps at TCK_DIV-1, held at zero while disabled
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (!en) begin
            div_cnt_d = '0;
        end else if (div_cnt_q == CW'(TCK_DIV - 1)) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + CW'(1);
        end
    end

    // Divider register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // Low half then high half; sample on the edge where tck goes high
    assign tck    = (div_cnt_q >= CW'(TCK_DIV / 2));
    assign tick   = en && (div_cnt_q == CW'(TCK_DIV - 1));
    assign sample = en && (div_cnt_q == CW'(TCK_DIV / 2 - 1));

endmodule

// File: rtl/nios_dbg_vjtag_master.sv
// Nios II debug-slave vJTAG initiator: one {ir,dr} command -> UIR,CDR,SDR xDR_WIDTH,UDR -> captured tdo.
// Latency: (DR_WIDTH+3)*TCK_DIV+1 clk accept->rsp_valid; +TCK_DIV when NIOS_DBG_VJTAG_RTI_EN is defined.
// Backpressure: cmd_ready low from accept until the response is taken; rsp_valid held until rsp_ready.
module nios_dbg_vjtag_master
    import nios_dbg_vjtag_pkg::*;
#(
    parameter int DR_WIDTH = DEF_DR_WIDTH,
    parameter int IR_WIDTH = DEF_IR_WIDTH,
    parameter int TCK_DIV  = DEF_TCK_DIV
) (
    input  logic                clk,
    input  logic                reset_n,
    nios_dbg_vjtag_if.slave     bus,
    output logic [IR_WIDTH-1:0] ir_in,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo
);
    localparam int BCW = (DR_WIDTH > 2) ? $clog2(DR_WIDTH) : 1;

    state_e              state_q, state_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [DR_WIDTH-1:0] shift_q, shift_d;
    logic [DR_WIDTH-1:0] cap_q, cap_d;
    logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;

    logic tck_en;
    logic tick;
    logic sample;

    // The divider only runs while the virtual TAP is being walked
    assign tck_en = (state_q != ST_IDLE) && (state_q != ST_DONE);

    nios_dbg_vjtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (tck_en),
        .tck     (tck),
        .tick    (tick),
        .sample  (sample)
    );

    // Next-state and datapath: states advance only on tick, tdo captured on the rising tck edge
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        shift_d     = shift_q;
        cap_d       = cap_q;
        rsp_dr_d    = rsp_dr_q;
        rsp_valid_d = rsp_valid_q;
        bit_cnt_d   = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    ir_d      = bus.cmd_ir;
                    shift_d   = bus.cmd_dr;
                    cap_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_UIR;
                end
            end
            ST_UIR: if (tick) state_d = ST_CDR;
            ST_CDR: if (tick) state_d = ST_SDR;
            ST_SDR: begin
                if (sample) begin
                    // First captured bit ends up in bit 0 after DR_WIDTH shifts
                    cap_d = {tdo, cap_q[DR_WIDTH-1:1]};
                end
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BCW'(DR_WIDTH - 1)) begin
                        state_d = ST_UDR;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            ST_UDR: begin
                rsp_dr_d = cap_q;
                if (tick) begin
`ifdef NIOS_DBG_VJTAG_RTI_EN
                    state_d = ST_RTI;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef NIOS_DBG_VJTAG_RTI_EN
            // Settle window for the debug slave's system-clock side
            ST_RTI: if (tick) state_d = ST_DONE;
`endif
            ST_DONE: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ir_q        <= '0;
            shift_q     <= '0;
            cap_q       <= '0;
            rsp_dr_q    <= '0;
            rsp_valid_q <= 1'b0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            shift_q     <= shift_d;
            cap_q       <= cap_d;
            rsp_dr_q    <= rsp_dr_d;
            rsp_valid_q <= rsp_valid_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign bus.cmd_ready  = (state_q == ST_IDLE);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_dr     = rsp_dr_q;
    assign ir_in          = ir_q;
    assign vs_uir         = (state_q == ST_UIR);
    assign vs_cdr         = (state_q == ST_CDR);
    assign vs_sdr         = (state_q == ST_SDR);
    assign vs_udr         = (state_q == ST_UDR);
    assign jtag_state_rti = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_RTI);
    assign tdi            = (state_q == ST_SDR) && shift_q[0];

endmodule
